// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the parametrised UART transmitter.
//   uart_state_t  : transmitter FSM states
//   uart_parity_t : encoding of the parity_mode input
//   calc_div()    : rounded integer clock-to-baud divider
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'd0,
        PAR_EVEN  = 2'd1,
        PAR_ODD   = 2'd2,
        PAR_NONE2 = 2'd3
    } uart_parity_t;

    // Rounded to nearest so the bit time error is at most half a clock.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// ---------------------------------------------------------------------------
// uart_tx_param_if
// Character handshake between the message sequencer (master) and the
// transmitter (slave).
//   tx_valid    master -> slave  character available on tx_data
//   tx_data     master -> slave  character, DATA_BITS wide, LSB sent first
//   parity_mode master -> slave  00 none, 01 even, 10 odd, 11 none
//   tx_ready    slave -> master  transmitter idle, accepts this cycle
//   tx_busy     slave -> master  inverse of tx_ready
//   tx_done     slave -> master  one-cycle pulse at end of the last stop bit
// DATA_BITS must match the DATA_BITS of the transmitter it is attached to.
// ---------------------------------------------------------------------------
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic [1:0]           parity_mode;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_valid, tx_data, parity_mode,
        input  tx_ready, tx_busy, tx_done
    );

    modport slave (
        input  tx_valid, tx_data, parity_mode,
        output tx_ready, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-time counter for the transmitter. Counts 0..DIV-1 while enabled and
// sits at 0 otherwise, so the first bit after an accept is a full DIV clocks.
//   FPGA_CLK1_50 in  system clock
//   rst_n        in  asynchronous active-low reset
//   clear        in  restart the count at 0
//   enable       in  count; when low the counter is held at 0
//   tick         out high on the last clock of each bit time
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIV = 4
) (
    input  logic FPGA_CLK1_50,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge FPGA_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
// Parametrised RS-232 transmitter: START, DATA_BITS data bits LSB first,
// optional parity, STOP_BITS stop bits, each bit DIV clocks long.
//   FPGA_CLK1_50 in  system clock, rising edge
//   rst_n        in  asynchronous active-low reset (aborts a frame in flight)
//   bus          slave modport of uart_tx_param_if (valid/ready handshake,
//                data, parity mode, busy, done)
//   TxD          out registered serial line, idle high
// Build option: define UART_TX_PARITY_EN to honour parity_mode; without it
// parity_mode is ignored and every frame is DATA_BITS-N-STOP_BITS.
// ---------------------------------------------------------------------------
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic             FPGA_CLK1_50,
    input  logic             rst_n,
    uart_tx_param_if.slave   bus,
    output logic             TxD
);
    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_param: CLK_HZ/BAUD gives a divider below 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_check
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 txd_q, txd_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 baud_tick;
    logic                 goto_parity;
    logic                 parity_bit;

    assign accept = bus.tx_valid && (state_q == IDLE);

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .FPGA_CLK1_50 (FPGA_CLK1_50),
        .rst_n        (rst_n),
        .clear        (accept),
        .enable       (state_q != IDLE),
        .tick         (baud_tick)
    );

`ifdef UART_TX_PARITY_EN
    // Parity bit and its enable are frozen at accept so later changes on
    // tx_data/parity_mode cannot disturb the frame in flight.
    logic parity_q;
    logic par_en_q;

    always_ff @(posedge FPGA_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
            par_en_q <= 1'b0;
        end else if (accept) begin
            par_en_q <= (bus.parity_mode == PAR_EVEN) || (bus.parity_mode == PAR_ODD);
            parity_q <= (bus.parity_mode == PAR_ODD) ? ~^bus.tx_data : ^bus.tx_data;
        end
    end

    assign goto_parity = par_en_q;
    assign parity_bit  = parity_q;
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^bus.parity_mode;
    assign goto_parity        = 1'b0;
    assign parity_bit         = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shift_d   = bus.tx_data;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = goto_parity ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level follows the next state so TxD changes on the same edge
        // as the state it belongs to (start bit low on the accept edge).
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = parity_bit;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge FPGA_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
        end
    end

    assign bus.tx_ready = (state_q == IDLE);
    assign bus.tx_busy  = (state_q != IDLE);
    assign bus.tx_done  = done_q;
    assign TxD          = txd_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_param
// Directed bench for uart_tx_param with CLK_HZ=400, BAUD=100 (4 clocks per
// bit). dut_a is 8 data bits / 1 stop bit, dut_b is 7 data bits / 2 stop
// bits. Parity expectations follow UART_TX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_uart_tx_param;
    localparam int CLK_HZ = 400;
    localparam int BAUD   = 100;
    localparam int DIV    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic txd_a;
    logic txd_b;

    uart_tx_param_if #(.DATA_BITS(8)) bus_a ();
    uart_tx_param_if #(.DATA_BITS(7)) bus_b ();

    uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .FPGA_CLK1_50 (clk),
        .rst_n        (rst_n),
        .bus          (bus_a),
        .TxD          (txd_a)
    );

    uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
        .FPGA_CLK1_50 (clk),
        .rst_n        (rst_n),
        .bus          (bus_b),
        .TxD          (txd_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic cap_txd  [0:511];
    logic cap_done [0:511];
    logic cap_rdy  [0:511];

    // Raise tx_valid on a falling edge; the following rising edge accepts.
    task automatic start_frame(input bit which, input logic [7:0] d, input logic [1:0] m);
        @(negedge clk);
        if (which) begin
            bus_b.tx_data     = d[6:0];
            bus_b.parity_mode = m;
            bus_b.tx_valid    = 1'b1;
        end else begin
            bus_a.tx_data     = d;
            bus_a.parity_mode = m;
            bus_a.tx_valid    = 1'b1;
        end
        @(posedge clk);
    endtask

    // Record one sample per clock on falling edges; cycle 0 is the first
    // falling edge after the accept edge. tx_valid drops at cycle drop_at.
    task automatic capture(input bit which, input int ncyc, input int drop_at);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cap_txd[c]  = which ? txd_b : txd_a;
            cap_done[c] = which ? bus_b.tx_done : bus_a.tx_done;
            cap_rdy[c]  = which ? bus_b.tx_ready : bus_a.tx_ready;
            if (c == drop_at) begin
                if (which) bus_b.tx_valid = 1'b0;
                else       bus_a.tx_valid = 1'b0;
            end
        end
    endtask

    // Bit value of each cell taken mid-cell, first bit on the line in bit 0.
    function automatic logic [15:0] cells(input int off, input int n);
        logic [15:0] r = '0;
        for (int j = 0; j < n; j++) r[j] = cap_txd[off + j*DIV + DIV/2];
        return r;
    endfunction

    // Every clock of every cell carries the same level as its mid sample.
    function automatic bit stable(input int off, input int n);
        for (int j = 0; j < n; j++)
            for (int k = 0; k < DIV; k++)
                if (cap_txd[off + j*DIV + k] !== cap_txd[off + j*DIV + DIV/2]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int first_done(input int from, input int lim);
        for (int c = from; c < lim; c++) if (cap_done[c] === 1'b1) return c;
        return -1;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (txd_a !== 1'b1) begin errors++; $display("FAIL reset_txd_held: got %b expected 1", txd_a); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (txd_a !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd_a); end
        checks++;
        if (bus_a.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus_a.tx_ready); end
        checks++;
        if (bus_a.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_a.tx_busy); end
        checks++;
        if (bus_a.tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus_a.tx_done); end
        checks++;
        if ({txd_b, bus_b.tx_ready, bus_b.tx_busy} !== 3'b110) begin
            errors++; $display("FAIL reset_b: got %b expected 110", {txd_b, bus_b.tx_ready, bus_b.tx_busy});
        end
        $display("reset: txd_a=%b ready_a=%b busy_a=%b done_a=%b", txd_a, bus_a.tx_ready, bus_a.tx_busy, bus_a.tx_done);
    endtask

    task automatic test_8n1();
        logic [15:0] exp_c;
        int d;
        exp_c = 16'b0000001101001010;   // 0, A5 LSB first, 1
        start_frame(1'b0, 8'hA5, 2'b00);
        capture(1'b0, 48, 0);
        d = first_done(0, 48);
        $display("8n1 0xA5: cells=%b done@%0d", cells(0, 10), d);
        checks++;
        if (cells(0, 10) !== exp_c) begin errors++; $display("FAIL 8n1_bits: got %b expected %b", cells(0, 10), exp_c); end
        checks++;
        if (!stable(0, 10)) begin errors++; $display("FAIL 8n1_cell_width: got unstable expected %0d clk cells", DIV); end
        checks++;
        if (d !== 40) begin errors++; $display("FAIL 8n1_done_time: got %0d expected 40", d); end
        checks++;
        if (cap_done[41] !== 1'b0) begin errors++; $display("FAIL 8n1_done_pulse: got %b expected 0", cap_done[41]); end
        checks++;
        if ({cap_rdy[0], cap_rdy[40]} !== 2'b01) begin
            errors++; $display("FAIL 8n1_ready: got %b expected 01", {cap_rdy[0], cap_rdy[40]});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp1;
        logic [15:0] exp2;
        int d1;
        int d2;
        exp1 = 16'b0000001000000000;    // 0, 00, 1
        exp2 = 16'b0000001111111110;    // 0, FF, 1
        start_frame(1'b0, 8'h00, 2'b00);
        fork
            capture(1'b0, 90, 41);
            begin @(negedge clk); bus_a.tx_data = 8'hFF; end
        join
        d1 = first_done(0, 90);
        d2 = first_done(41, 90);
        $display("b2b 0x00: done@%0d  0xFF: start@41 done@%0d", d1, d2);
        checks++;
        if (d1 !== 40) begin errors++; $display("FAIL b2b_done1: got %0d expected 40", d1); end
        checks++;
        if (cells(0, 10) !== exp1) begin errors++; $display("FAIL b2b_bits1: got %b expected %b", cells(0, 10), exp1); end
        checks++;
        if ({cap_txd[40], cap_txd[41]} !== 2'b10) begin
            errors++; $display("FAIL b2b_gap: got %b expected 10", {cap_txd[40], cap_txd[41]});
        end
        checks++;
        if (cells(41, 10) !== exp2 || !stable(41, 10)) begin
            errors++; $display("FAIL b2b_bits2: got %b expected %b", cells(41, 10), exp2);
        end
        checks++;
        if (d2 !== 81) begin errors++; $display("FAIL b2b_done2: got %0d expected 81", d2); end
    endtask

    task automatic test_parity();
        int d;
`ifdef UART_TX_PARITY_EN
        logic [15:0] exp_e;
        logic [15:0] exp_o;
        logic [15:0] exp_n;
        exp_e = 16'b0000011000001110;   // 0, 07, parity 1, 1
        exp_o = 16'b0000010000001110;   // 0, 07, parity 0, 1
        exp_n = 16'b0000001000001110;   // 0, 07, 1
        start_frame(1'b0, 8'h07, 2'b01);
        capture(1'b0, 52, 0);
        d = first_done(0, 52);
        $display("parity even 0x07: cells=%b done@%0d", cells(0, 11), d);
        checks++;
        if (cells(0, 11) !== exp_e || !stable(0, 11)) begin
            errors++; $display("FAIL par_even_bits: got %b expected %b", cells(0, 11), exp_e);
        end
        checks++;
        if (d !== 44) begin errors++; $display("FAIL par_even_done: got %0d expected 44", d); end
        start_frame(1'b0, 8'h07, 2'b10);
        capture(1'b0, 52, 0);
        d = first_done(0, 52);
        $display("parity odd 0x07: cells=%b done@%0d", cells(0, 11), d);
        checks++;
        if (cells(0, 11) !== exp_o || !stable(0, 11)) begin
            errors++; $display("FAIL par_odd_bits: got %b expected %b", cells(0, 11), exp_o);
        end
        checks++;
        if (d !== 44) begin errors++; $display("FAIL par_odd_done: got %0d expected 44", d); end
        start_frame(1'b0, 8'h07, 2'b11);
        capture(1'b0, 48, 0);
        d = first_done(0, 48);
        $display("parity mode 11 0x07: cells=%b done@%0d", cells(0, 10), d);
        checks++;
        if (cells(0, 10) !== exp_n || d !== 40) begin
            errors++; $display("FAIL par_none2: got %b/%0d expected %b/40", cells(0, 10), d, exp_n);
        end
`else
        logic [15:0] exp_n;
        exp_n = 16'b0000001000001110;   // 0, 07, 1 -- mode ignored
        start_frame(1'b0, 8'h07, 2'b01);
        capture(1'b0, 48, 0);
        d = first_done(0, 48);
        $display("parity disabled mode 01 0x07: cells=%b done@%0d", cells(0, 10), d);
        checks++;
        if (cells(0, 10) !== exp_n || !stable(0, 10)) begin
            errors++; $display("FAIL nopar_bits: got %b expected %b", cells(0, 10), exp_n);
        end
        checks++;
        if (d !== 40) begin errors++; $display("FAIL nopar_done: got %0d expected 40", d); end
`endif
    endtask

    task automatic test_7bit_2stop();
        logic [15:0] exp1;
        logic [15:0] exp2;
        int d;
        exp1 = 16'b0000001111111110;    // 0, seven 1s, 1, 1
        exp2 = 16'b0000001101010100;    // 0, 2A LSB first, 1, 1
        start_frame(1'b1, 8'h7F, 2'b00);
        capture(1'b1, 48, 0);
        d = first_done(0, 48);
        $display("7n2 0x7F: cells=%b done@%0d", cells(0, 10), d);
        checks++;
        if (cells(0, 10) !== exp1 || !stable(0, 10)) begin
            errors++; $display("FAIL w7_7f_bits: got %b expected %b", cells(0, 10), exp1);
        end
        checks++;
        if (d !== 40) begin errors++; $display("FAIL w7_7f_done: got %0d expected 40", d); end
        start_frame(1'b1, 8'h2A, 2'b00);
        capture(1'b1, 48, 0);
        d = first_done(0, 48);
        $display("7n2 0x2A: cells=%b done@%0d", cells(0, 10), d);
        checks++;
        if (cells(0, 10) !== exp2 || !stable(0, 10)) begin
            errors++; $display("FAIL w7_2a_bits: got %b expected %b", cells(0, 10), exp2);
        end
        checks++;
        if (d !== 40) begin errors++; $display("FAIL w7_2a_done: got %0d expected 40", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] exp_c;
        int d;
        exp_c = 16'b0000001100101100;   // 0, 96 LSB first, 1
        start_frame(1'b0, 8'hC3, 2'b00);
        @(negedge clk);
        bus_a.tx_valid = 1'b0;
        repeat (17) @(negedge clk);     // cycle 17: data bit 3 of 0xC3 = 0
        checks++;
        if (txd_a !== 1'b0) begin errors++; $display("FAIL midrst_pre_txd: got %b expected 0", txd_a); end
        rst_n = 1'b0;
        #1;
        $display("reset mid-frame: txd=%b ready=%b busy=%b", txd_a, bus_a.tx_ready, bus_a.tx_busy);
        checks++;
        if (txd_a !== 1'b1) begin errors++; $display("FAIL midrst_txd: got %b expected 1", txd_a); end
        checks++;
        if ({bus_a.tx_ready, bus_a.tx_busy} !== 2'b10) begin
            errors++; $display("FAIL midrst_ready: got %b expected 10", {bus_a.tx_ready, bus_a.tx_busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_frame(1'b0, 8'h96, 2'b00);
        capture(1'b0, 48, 0);
        d = first_done(0, 48);
        $display("after reset 0x96: cells=%b done@%0d", cells(0, 10), d);
        checks++;
        if (cells(0, 10) !== exp_c || !stable(0, 10)) begin
            errors++; $display("FAIL midrst_next_bits: got %b expected %b", cells(0, 10), exp_c);
        end
        checks++;
        if (d !== 40) begin errors++; $display("FAIL midrst_next_done: got %0d expected 40", d); end
    endtask

    task automatic test_data_hold();
        logic [15:0] exp_c;
        int d;
        exp_c = 16'b0000001010110100;   // 0, 5A LSB first, 1
        start_frame(1'b0, 8'h5A, 2'b00);
        fork
            capture(1'b0, 48, 0);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                bus_a.tx_data     = ~bus_a.tx_data;
                bus_a.parity_mode = ~bus_a.parity_mode;
            end
        join
        d = first_done(0, 48);
        $display("data toggled while busy 0x5A: cells=%b done@%0d", cells(0, 10), d);
        checks++;
        if (cells(0, 10) !== exp_c || !stable(0, 10)) begin
            errors++; $display("FAIL hold_bits: got %b expected %b", cells(0, 10), exp_c);
        end
        checks++;
        if (d !== 40) begin errors++; $display("FAIL hold_done: got %0d expected 40", d); end
    endtask

    initial begin
        bus_a.tx_valid = 1'b0; bus_a.tx_data = '0; bus_a.parity_mode = 2'b00;
        bus_b.tx_valid = 1'b0; bus_b.tx_data = '0; bus_b.parity_mode = 2'b00;
        test_reset();
        test_8n1();
        test_back_to_back();
        test_parity();
        test_7bit_2stop();
        test_reset_mid_frame();
        test_data_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit in case a wait never completes.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
